// File: rtl/apb_intc_if.sv
`timescale 1ns/1ps
// APB bus bundle for the interrupt-controller slot (psel_s4) of the peripheral subsystem.
interface apb_intc_if;
  logic        psel;
  logic        penable;
  logic [15:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;

  modport master (output psel, penable, paddr, pwrite, pwdata, input prdata);
  modport slave  (input psel, penable, paddr, pwrite, pwdata, output prdata);
endinterface

// File: rtl/apb_intc.sv
`timescale 1ns/1ps
// Fixed-priority APB interrupt controller: per-source gateway, enables, claim/complete
// handshake and a single registered level interrupt to the core.
module apb_intc #(
  parameter int NUM_SRC = 40
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_intc_if.slave          apb,
  input  logic [NUM_SRC-1:0] int_src,
  output logic               intc_irq
);

  // All per-source state lives in 64-bit vectors; bits at and above NUM_SRC stay zero.
  localparam logic [63:0] SRC_MASK = (NUM_SRC >= 64) ? {64{1'b1}} : ((64'd1 << NUM_SRC) - 64'd1);

  localparam logic [7:0] A_IER0  = 8'h00;
  localparam logic [7:0] A_IER1  = 8'h04;
  localparam logic [7:0] A_IPR0  = 8'h08;
  localparam logic [7:0] A_IPR1  = 8'h0C;
  localparam logic [7:0] A_CLAIM = 8'h10;
  localparam logic [7:0] A_CTRL  = 8'h14;
  localparam logic [7:0] A_ISR0  = 8'h18;
  localparam logic [7:0] A_ISR1  = 8'h1C;

  logic [63:0] ier;
  logic [63:0] src_q;
  logic [63:0] pending;
  logic [63:0] in_service;
  logic [63:0] cand;
  logic [63:0] claim_vec;
  logic [63:0] cpl_vec;
  logic        gen;
  logic [6:0]  claim_id;
  logic [6:0]  cpl_id;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_acc;
  logic        unused_paddr;

  assign addr         = apb.paddr[7:0];
  assign unused_paddr = ^apb.paddr[15:8];
  assign wr_en        = apb.psel & apb.penable & apb.pwrite;
  assign rd_acc       = apb.psel & apb.penable & ~apb.pwrite;
  assign cand         = pending & ier;

  // Scanning downwards leaves the lowest set index as the winner.
  always_comb begin
    claim_id = 7'd0;
    for (int i = 63; i >= 0; i--) begin
      if (cand[i]) claim_id = 7'(i + 1);
    end
  end

  assign claim_vec = (rd_acc && addr == A_CLAIM && claim_id != 7'd0)
                     ? (64'd1 << (claim_id - 7'd1)) : 64'd0;

  // A complete only takes effect on an in-range ID that is actually in service.
  assign cpl_id  = apb.pwdata[6:0];
  assign cpl_vec = (wr_en && addr == A_CLAIM && cpl_id != 7'd0 && 32'(cpl_id) <= NUM_SRC)
                   ? ((64'd1 << (cpl_id - 7'd1)) & in_service) : 64'd0;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ier        <= 64'd0;
      gen        <= 1'b0;
      src_q      <= 64'd0;
      pending    <= 64'd0;
      in_service <= 64'd0;
      intc_irq   <= 1'b0;
    end else begin
      src_q      <= 64'(int_src);
      pending    <= (pending | (src_q & ~in_service)) & ~claim_vec;
      in_service <= (in_service | claim_vec) & ~cpl_vec;
      intc_irq   <= gen & (|cand);
      if (wr_en) begin
        case (addr)
          A_IER0:  ier[31:0]  <= apb.pwdata & SRC_MASK[31:0];
          A_IER1:  ier[63:32] <= apb.pwdata & SRC_MASK[63:32];
          A_CTRL:  gen        <= apb.pwdata[0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    apb.prdata = 32'd0;
    if (apb.psel && !apb.pwrite) begin
      case (addr)
        A_IER0:  apb.prdata = ier[31:0];
        A_IER1:  apb.prdata = ier[63:32];
        A_IPR0:  apb.prdata = pending[31:0];
        A_IPR1:  apb.prdata = pending[63:32];
        A_CLAIM: apb.prdata = 32'(claim_id);
        A_CTRL:  apb.prdata = {31'd0, gen};
        A_ISR0:  apb.prdata = in_service[31:0];
        A_ISR1:  apb.prdata = in_service[63:32];
        default: apb.prdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_intc.sv
`timescale 1ns/1ps
// Scoreboard bench for apb_intc: per-source reference model, queued read expectations,
// directed scenarios followed by randomized APB traffic and source activity.
module tb_apb_intc;

  localparam int NUM_SRC = 40;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } sb_entry_t;

  logic               pclk    = 1'b0;
  logic               presetn = 1'b0;
  logic [NUM_SRC-1:0] int_src = '0;
  logic               intc_irq;

  apb_intc_if apb();

  apb_intc #(.NUM_SRC(NUM_SRC)) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .apb      (apb),
    .int_src  (int_src),
    .intc_irq (intc_irq)
  );

  int        n_checks = 0;
  int        n_errors = 0;
  sb_entry_t sb_q[$];

  // Reference model: one entry per source, updated by the rules of the gateway.
  bit m_srcq[64];
  bit m_pend[64];
  bit m_insvc[64];
  bit m_ier[64];
  bit m_gen;
  bit m_irq;

  always #5 pclk = ~pclk;

  function automatic int model_claim_id();
    for (int i = 0; i < NUM_SRC; i++) begin
      if (m_pend[i] && m_ier[i]) return i + 1;
    end
    return 0;
  endfunction

  function automatic logic [31:0] pack_word(input bit a[64], input int base);
    logic [31:0] v = 32'd0;
    for (int j = 0; j < 32; j++) begin
      if (base + j < NUM_SRC) v[j] = a[base + j];
    end
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    case (a)
      8'h00:   return pack_word(m_ier, 0);
      8'h04:   return pack_word(m_ier, 32);
      8'h08:   return pack_word(m_pend, 0);
      8'h0C:   return pack_word(m_pend, 32);
      8'h10:   return 32'(model_claim_id());
      8'h14:   return {31'd0, m_gen};
      8'h18:   return pack_word(m_insvc, 0);
      8'h1C:   return pack_word(m_insvc, 32);
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge pclk or negedge presetn) begin : model
    int         cid;
    int         k;
    bit         acc;
    bit         any_en;
    bit         nxt_p;
    bit         nxt_s;
    logic [7:0] a;
    if (!presetn) begin
      for (int i = 0; i < 64; i++) begin
        m_srcq[i]  <= 1'b0;
        m_pend[i]  <= 1'b0;
        m_insvc[i] <= 1'b0;
        m_ier[i]   <= 1'b0;
      end
      m_gen <= 1'b0;
      m_irq <= 1'b0;
    end else begin
      cid    = model_claim_id();
      a      = apb.paddr[7:0];
      acc    = apb.psel && apb.penable;
      k      = int'(apb.pwdata[6:0]);
      any_en = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
        nxt_p = m_pend[i] || (m_srcq[i] && !m_insvc[i]);
        nxt_s = m_insvc[i];
        if (acc && !apb.pwrite && a == 8'h10 && cid == i + 1) begin
          nxt_p = 1'b0;
          nxt_s = 1'b1;
        end
        if (acc && apb.pwrite && a == 8'h10 && k == i + 1) nxt_s = 1'b0;
        m_pend[i]  <= nxt_p;
        m_insvc[i] <= nxt_s;
        m_srcq[i]  <= int_src[i];
        if (acc && apb.pwrite && a == 8'h00 && i < 32)  m_ier[i] <= apb.pwdata[i];
        if (acc && apb.pwrite && a == 8'h04 && i >= 32) m_ier[i] <= apb.pwdata[i-32];
        if (m_pend[i] && m_ier[i]) any_en = 1'b1;
      end
      m_irq <= m_gen && any_en;
      if (acc && apb.pwrite && a == 8'h14) m_gen <= apb.pwdata[0];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: irq every cycle, and one queued expectation per read access phase.
  always @(negedge pclk) begin
    sb_entry_t e;
    checkOutput("intc_irq", 32'(intc_irq), 32'(m_irq));
    if (apb.psel && apb.penable && !apb.pwrite) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("[TB] FAIL read_unexpected: got 0x%08h, expected no read", apb.prdata);
      end else begin
        e = sb_q.pop_front();
        checkOutput($sformatf("read_%02h", e.addr), apb.prdata, e.exp);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_SRC-1:0] v);
    int_src = v;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    apb.psel    = 1'b1;
    apb.pwrite  = 1'b1;
    apb.penable = 1'b0;
    apb.paddr   = {8'($urandom), a};
    apb.pwdata  = d;
    idle(1);
    apb.penable = 1'b1;
    idle(1);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a);
    apb.psel    = 1'b1;
    apb.pwrite  = 1'b0;
    apb.penable = 1'b0;
    apb.paddr   = {8'($urandom), a};
    idle(1);
    apb.penable = 1'b1;
    sb_q.push_back('{addr: a, exp: model_read(a)});
    idle(1);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    idle(2);
    presetn = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  addrs [11];
    logic [63:0] r;
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h40, 8'h02};
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = '0; apb.pwdata = '0;

    $display("[TB] reset with all sources high");
    applyStimulus('1);
    idle(2);
    checkOutput("irq_in_reset", 32'(intc_irq), 32'd0);
    apb_read(8'h00); apb_read(8'h08); apb_read(8'h10); apb_read(8'h18);
    presetn = 1'b1;
    idle(3);
    checkOutput("irq_gen_off", 32'(intc_irq), 32'd0);
    apb_read(8'h08); apb_read(8'h0C);

    $display("[TB] single pulse claim/complete");
    applyStimulus('0);
    do_reset();
    apb_write(8'h00, 32'h12);
    apb_write(8'h14, 32'h1);
    applyStimulus(40'h2);
    idle(1);
    applyStimulus('0);
    idle(2);
    checkOutput("irq_after_pulse", 32'(intc_irq), 32'd1);
    apb_read(8'h08); apb_read(8'h10);
    idle(1);
    checkOutput("irq_after_claim", 32'(intc_irq), 32'd0);
    apb_read(8'h08); apb_read(8'h18);
    apb_write(8'h10, 32'd2);
    apb_read(8'h18);

    $display("[TB] two held sources, priority and re-arm");
    applyStimulus(40'h12);
    idle(3);
    apb_read(8'h10); apb_read(8'h10); apb_read(8'h10);
    apb_write(8'h10, 32'd5);
    idle(1);
    apb_read(8'h08);
    checkOutput("irq_rearm", 32'(intc_irq), 32'd1);
    apb_write(8'h10, 32'd2);
    apb_read(8'h18);

    $display("[TB] upper source bank");
    applyStimulus(40'h80_0000_0000);
    do_reset();
    apb_write(8'h04, 32'hFFFF_FFFF);
    apb_read(8'h04);
    apb_write(8'h14, 32'h1);
    idle(3);
    apb_read(8'h10);
    apb_write(8'h10, 32'd41);
    apb_write(8'h10, 32'd0);
    apb_read(8'h1C);
    apb_write(8'h10, 32'd40);
    apb_read(8'h1C);

    $display("[TB] masked source then enable");
    applyStimulus(40'h8);
    do_reset();
    apb_write(8'h14, 32'h1);
    idle(3);
    checkOutput("irq_masked", 32'(intc_irq), 32'd0);
    apb_read(8'h10); apb_read(8'h08);
    apb_write(8'h00, 32'h8);
    checkOutput("irq_at_ier_edge", 32'(intc_irq), 32'd0);
    idle(1);
    checkOutput("irq_after_ier", 32'(intc_irq), 32'd1);

    $display("[TB] async reset mid-claim");
    applyStimulus(40'h5);
    do_reset();
    apb_write(8'h00, 32'h5);
    apb_write(8'h14, 32'h1);
    idle(3);
    apb_read(8'h10);
    checkOutput("irq_before_reset", 32'(intc_irq), 32'd1);
    #2 presetn = 1'b0;
    #1 checkOutput("irq_async_reset", 32'(intc_irq), 32'd0);
    apb_read(8'h18); apb_read(8'h40);
    presetn = 1'b1;
    apb_read(8'h40);

    $display("[TB] randomized traffic");
    applyStimulus('0);
    do_reset();
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
          applyStimulus(r[NUM_SRC-1:0]);
          idle(1);
        end
        2:    apb_write(8'h00, $urandom);
        3:    apb_write(8'h04, $urandom);
        4:    apb_write(8'h14, $urandom);
        5:    apb_read(addrs[$urandom_range(0, 10)]);
        6, 7: apb_read(8'h10);
        8:    apb_write(8'h10, 32'($urandom_range(0, 45)));
        default: begin
          if ($urandom_range(0, 9) == 0) begin
            #2 presetn = 1'b0;
            idle(1);
            presetn = 1'b1;
          end else begin
            idle($urandom_range(1, 3));
          end
        end
      endcase
    end

    idle(3);
    checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
